// File: rtl/oven_cook_ctrl.sv
// oven_cook_ctrl
//   Main cook sequencer of the oven. Takes single-cycle button events
//   (add-time, start, stop), the dual-hold abort pulse and the door level.
//   It counts cook time down in seconds, drives heater and lamp, and sounds
//   a finish beep.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active low
//   add_p      1-cycle pulse: add STEP_SEC seconds (saturates at MAX_SEC)
//   start_p    1-cycle pulse: start / resume cooking
//   stop_p     1-cycle pulse: pause while cooking, clear otherwise
//   clear_p    1-cycle pulse: abort everything, back to IDLE
//   door_open  level, 1 = door open
//   heater     heating element enable (registered)
//   lamp       cavity lamp (registered)
//   beep       buzzer enable (registered)
//   remain     remaining seconds, 0..MAX_SEC (registered)
//   state      FSM state code for display/debug
//
// Build option
//   OVEN_AUTO_RESUME_EN : a PAUSE caused by opening the door resumes COOK on
//                         its own when the door closes again.
//
// State | meaning
//   IDLE  (0) | no time set, everything off
//   SET   (1) | time being entered, waiting for start
//   COOK  (2) | heating, counting remaining time down
//   PAUSE (3) | cooking suspended, time frozen
//   DONE  (4) | cook finished, beeping for BEEP_SEC seconds

module oven_cook_ctrl #(
  parameter int unsigned SECONDS  = 50_000_000,
  parameter int unsigned STEP_SEC = 30,
  parameter int unsigned MAX_SEC  = 5999,
  parameter int unsigned BEEP_SEC = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        add_p,
  input  logic        start_p,
  input  logic        stop_p,
  input  logic        clear_p,
  input  logic        door_open,
  output logic        heater,
  output logic        lamp,
  output logic        beep,
  output logic [12:0] remain,
  output logic [2:0]  state
);

  localparam int unsigned PW = $clog2(BEEP_SEC * SECONDS);
  localparam logic [PW-1:0] SEC_TC  = PW'(SECONDS - 1);
  localparam logic [PW-1:0] BEEP_TC = PW'(BEEP_SEC * SECONDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [12:0]    remain_q, remain_d;
  logic [PW-1:0]  presc_q, presc_d;

  logic [13:0]    add_sum;
  logic [12:0]    add_sat;
  logic [12:0]    cook_base;
  logic           tick;

  // 14-bit sum so that MAX_SEC + STEP_SEC can never wrap before the clamp
  assign add_sum   = {1'b0, remain_q} + 14'(STEP_SEC);
  assign add_sat   = (add_sum > 14'(MAX_SEC)) ? 13'(MAX_SEC) : add_sum[12:0];
  // In COOK a start_p outranks add_p, so it swallows a simultaneous add
  assign cook_base = (add_p && !start_p) ? add_sat : remain_q;
  assign tick      = (presc_q == SEC_TC);

`ifdef OVEN_AUTO_RESUME_EN
  logic door_q;
  logic door_pause_q, door_pause_d;
  logic door_close;

  // Only a pause that the door itself caused is resumed by closing it
  assign door_close = door_pause_q && door_q && !door_open;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      door_q       <= 1'b0;
      door_pause_q <= 1'b0;
    end else begin
      door_q       <= door_open;
      door_pause_q <= door_pause_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    presc_d  = presc_q;
`ifdef OVEN_AUTO_RESUME_EN
    door_pause_d = door_pause_q;
`endif
    if (clear_p) begin
      state_d  = S_IDLE;
      remain_d = '0;
      presc_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!stop_p && !start_p && add_p) begin
            state_d  = S_SET;
            remain_d = add_sat;
          end
        end
        S_SET: begin
          if (stop_p) begin
            state_d  = S_IDLE;
            remain_d = '0;
            presc_d  = '0;
          end else if (start_p) begin
            if (!door_open) begin
              state_d = S_COOK;
              presc_d = '0;
            end
          end else if (add_p) begin
            remain_d = add_sat;
          end
        end
        S_COOK: begin
          if (door_open) begin
            state_d = S_PAUSE;
`ifdef OVEN_AUTO_RESUME_EN
            door_pause_d = 1'b1;
`endif
          end else if (stop_p) begin
            state_d = S_PAUSE;
`ifdef OVEN_AUTO_RESUME_EN
            door_pause_d = 1'b0;
`endif
          end else if (tick) begin
            presc_d = '0;
            if (cook_base == 13'd1) begin
              state_d  = S_DONE;
              remain_d = '0;
            end else begin
              remain_d = cook_base - 13'd1;
            end
          end else begin
            presc_d  = presc_q + 1'b1;
            remain_d = cook_base;
          end
        end
        S_PAUSE: begin
`ifdef OVEN_AUTO_RESUME_EN
          if (door_close) begin
            state_d = S_COOK;
          end else
`endif
          if (stop_p) begin
            state_d  = S_IDLE;
            remain_d = '0;
            presc_d  = '0;
          end else if (start_p) begin
            // prescaler is kept so the partial second already cooked counts
            if (!door_open) state_d = S_COOK;
          end else if (add_p) begin
            remain_d = add_sat;
          end
        end
        S_DONE: begin
          if (stop_p || start_p || add_p || (presc_q == BEEP_TC)) begin
            state_d = S_IDLE;
            presc_d = '0;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: begin
          state_d  = S_IDLE;
          remain_d = '0;
          presc_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      presc_q  <= '0;
      heater   <= 1'b0;
      lamp     <= 1'b0;
      beep     <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      presc_q  <= presc_d;
      // Outputs are decoded from the next state so they move on the same
      // edge as the state register.
      heater   <= (state_d == S_COOK);
      lamp     <= (state_d == S_COOK) || (state_d == S_PAUSE) || door_open;
      beep     <= (state_d == S_DONE);
    end
  end

  assign remain = remain_q;
  assign state  = state_q;

endmodule
